// File: rtl/handshake_join_sync.sv
// handshake_join_sync: N-channel dual-rail join stage with completion detection.
// Synchronises the dual-rail inputs and waits for a complete codeword on every
// channel. It then captures the word and re-emits it under a four-phase
// return-to-zero handshake. It also flags illegal codes and long stalls.
module handshake_join_sync #(
  parameter int CH          = 2,
  parameter int BIT         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023,
  parameter int TW          = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CH*BIT-1:0]   dt,
  input  logic [CH*BIT-1:0]   df,
  input  logic                ack_nxt,
  output logic                ack_prev,
  output logic [CH*BIT-1:0]   out_dt,
  output logic [CH*BIT-1:0]   out_df,
  output logic                inv,
  output logic [CH-1:0]       chan_valid,
  output logic                err,
  output logic                timeout
);

  localparam int W  = CH * BIT;
  // With TIMEOUT = 0 the derived width is zero, so keep at least one bit.
  localparam int CW = (TW < 1) ? 1 : TW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_OUT_RTZ = 2'd2,
    S_IN_RTZ  = 2'd3
  } state_t;

  logic [W-1:0] dt_sync;
  logic [W-1:0] df_sync;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign dt_sync = dt;
      assign df_sync = df;
    end else begin : g_sync
      logic [W-1:0] dt_pipe_reg [SYNC_STAGES];
      logic [W-1:0] df_pipe_reg [SYNC_STAGES];

      // Shift both rail sets through the synchroniser chain.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            dt_pipe_reg[i] <= '0;
            df_pipe_reg[i] <= '0;
          end
        end else begin
          dt_pipe_reg[0] <= dt;
          df_pipe_reg[0] <= df;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            dt_pipe_reg[i] <= dt_pipe_reg[i-1];
            df_pipe_reg[i] <= df_pipe_reg[i-1];
          end
        end
      end

      assign dt_sync = dt_pipe_reg[SYNC_STAGES-1];
      assign df_sync = df_pipe_reg[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Dual-rail decode and completion detection
  // ---------------------------------------------------------------------------
  logic [W-1:0] valid_bits;
  logic [W-1:0] spacer_bits;
  logic [W-1:0] illegal_bits;
  logic         all_valid;
  logic         all_spacer;
  logic         any_illegal;

  assign valid_bits   = dt_sync ^ df_sync;
  assign spacer_bits  = ~dt_sync & ~df_sync;
  assign illegal_bits = dt_sync & df_sync;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_chan
      assign chan_valid[gi] = &valid_bits[gi*BIT +: BIT];
    end
  endgenerate

  assign all_valid   = &chan_valid;
  assign all_spacer  = &spacer_bits;
  assign any_illegal = |illegal_bits;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  state_t       state_reg, state_next;
  logic         ack_prev_reg, ack_prev_next;
  logic         inv_reg, inv_next;
  logic [W-1:0] out_dt_reg, out_dt_next;
  logic [W-1:0] out_df_reg, out_df_next;
  logic         err_reg;

  // Next-state and registered-output logic.
  always_comb begin
    state_next    = state_reg;
    ack_prev_next = ack_prev_reg;
    inv_next      = inv_reg;
    out_dt_next   = out_dt_reg;
    out_df_next   = out_df_reg;
    case (state_reg)
      S_IDLE: begin
        if (all_valid && !ack_nxt && !err_reg) begin
          out_dt_next   = dt_sync;
          out_df_next   = df_sync;
          ack_prev_next = 1'b1;
          inv_next      = 1'b1;
          state_next    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ack_nxt && all_spacer) begin
          out_dt_next   = '0;
          out_df_next   = '0;
          ack_prev_next = 1'b0;
          inv_next      = 1'b0;
          state_next    = S_IDLE;
        end else if (ack_nxt) begin
          out_dt_next = '0;
          out_df_next = '0;
          inv_next    = 1'b0;
          state_next  = S_OUT_RTZ;
        end else if (all_spacer) begin
          ack_prev_next = 1'b0;
          state_next    = S_IN_RTZ;
        end
      end
      S_OUT_RTZ: begin
        if (all_spacer) begin
          ack_prev_next = 1'b0;
          state_next    = S_IDLE;
        end
      end
      S_IN_RTZ: begin
        if (ack_nxt) begin
          out_dt_next = '0;
          out_df_next = '0;
          inv_next    = 1'b0;
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      ack_prev_reg <= 1'b0;
      inv_reg      <= 1'b0;
      out_dt_reg   <= '0;
      out_df_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      ack_prev_reg <= ack_prev_next;
      inv_reg      <= inv_next;
      out_dt_reg   <= out_dt_next;
      out_df_reg   <= out_df_next;
    end
  end

  // Sticky illegal-code flag; blocks further captures until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (any_illegal) begin
      err_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall timeout
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          timeout_reg;

  // Count cycles spent outside idle, saturating at the limit.
  always_comb begin
    cnt_next = cnt_reg;
    if (TIMEOUT == 0 || state_next == S_IDLE) begin
      cnt_next = '0;
    end else if (state_reg != S_IDLE && cnt_reg < CW'(TIMEOUT)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Counter register and sticky stall flag (report only).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (TIMEOUT != 0 && cnt_next == CW'(TIMEOUT)) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign ack_prev = ack_prev_reg;
  assign inv      = inv_reg;
  assign out_dt   = out_dt_reg;
  assign out_df   = out_df_reg;
  assign err      = err_reg;
  assign timeout  = timeout_reg;

endmodule

// File: doc/handshake_join_sync.md
Name: handshake_join_sync

Overview:
- Parametrised N-channel dual-rail join stage with completion detection, running on a single clock.
- Waits until every input channel carries a complete dual-rail codeword, then captures the data and re-emits it as one dual-rail word.
- Runs a four-phase return-to-zero handshake on both sides.
- Adds behaviour the two-channel join lacks: arbitrary channel count and width, input synchronisers, illegal-code detection, and a stall timeout.
- Sits between dual-rail producer stages and the synchronous accelerator datapath.

Parameters:
- CH, 2, number of dual-rail input channels joined (≥1).
- BIT, 8, bits per channel.
- SYNC_STAGES, 2, flop stages on dt/df before decode (0 = none).
- TIMEOUT, 1023, cycles allowed outside S_IDLE before timeout sets (0 = disabled).
- TW, $clog2(TIMEOUT+1), timeout counter width (derived).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- dt  input  CH*BIT  true rails; channel c = bits [c*BIT +: BIT].
- df  input  CH*BIT  false rails, same packing.
- ack_nxt  input  1  acknowledge from next stage (four-phase).
- ack_prev  output  1  acknowledge to producers.
- out_dt  output  CH*BIT  true rails of captured word.
- out_df  output  CH*BIT  false rails of captured word.
- inv  output  1  1 while out_dt/out_df carry data; 0 while spacer.
- chan_valid  output  CH  per-channel complete-codeword status (decoded, after sync).
- err  output  1  sticky illegal-code flag.
- timeout  output  1  sticky stall flag.

Behaviour:
- Reset (synchronous, dominant over all events, including mid-transaction):
  - state = S_IDLE.
  - ack_prev, inv, err, timeout = 0.
  - out_dt = out_df = 0 (spacer).
  - Synchroniser flops and timeout counter cleared.
- Decode, on synchronised rails per bit i:
  - valid = dt^df.
  - spacer = ~dt&~df.
  - illegal = dt&df.
- Channel and word status:
  - chan_valid[c] = AND of valid over the channel's BIT bits.
  - all_valid = AND of chan_valid.
  - all_spacer = every bit is spacer.
  - Mixed states (partial) are neither.
- err: set on any clock where any bit is illegal. Stays set until reset. While err = 1, no new capture.
- FSM (registered outputs, updated on the edge where the condition holds):
  - S_IDLE: ack_prev = 0, spacer out. If all_valid & ~ack_nxt & ~err: out_dt ← dt_sync, out_df ← df_sync, ack_prev ← 1, inv ← 1, go to S_HOLD. all_valid with ack_nxt = 1 waits; nothing is lost because the producer holds data until acked.
  - S_HOLD: both ack_nxt = 1 & all_spacer in the same cycle → spacer out, ack_prev ← 0, inv ← 0, go to S_IDLE. Else ack_nxt = 1 only → spacer out, inv ← 0, go to S_OUT_RTZ. Else all_spacer only → ack_prev ← 0, go to S_IN_RTZ.
  - S_OUT_RTZ: output already spacer, ack_prev = 1. all_spacer → ack_prev ← 0, go to S_IDLE.
  - S_IN_RTZ: ack_prev = 0, output still data. ack_nxt = 1 → spacer out, inv ← 0, go to S_IDLE.
  - Input data changes while in S_HOLD / S_IN_RTZ do not alter out_dt/out_df; the captured word holds.
- Latency: from input rails becoming all_valid to ack_prev = 1 and out valid is SYNC_STAGES+1 rising edges. The same latency applies from all_spacer to ack_prev = 0.
- Timeout counter:
  - Increments each cycle state ≠ S_IDLE; saturates at TIMEOUT.
  - Clears on entry to S_IDLE.
  - timeout sets when the counter reaches TIMEOUT and is sticky until reset.
  - The flag only reports; it does not change FSM flow.
  - TIMEOUT = 0: counter and flag held at 0.
- CH = 1 is legal; the block degenerates to a single-channel completion stage.

Test Plan:
- CH=2, BIT=4, SYNC_STAGES=2. Reset held 2 cycles, then dt=8'hA5, df=8'h5A, ack_nxt=0 → ack_prev=1, out_dt=8'hA5, out_df=8'h5A, inv=1 exactly 3 edges after input applied. chan_valid=2'b11.
- Only channel 0 valid (dt=8'h05, df=8'h0A) → chan_valid=2'b01, ack_prev stays 0 for 20 cycles. Then channel 1 completes → capture on edge 3 after.
- From S_HOLD, raise ack_nxt and drive spacer on the same cycle → single transition to S_IDLE: ack_prev=0, out=spacer, inv=0 on the same edge. Second word 8'h3C is then captured correctly after ack_nxt=0.
- From S_HOLD, spacer inputs first (→ S_IN_RTZ, ack_prev=0, out still 8'hA5). Then ack_nxt=1 → out spacer. Repeat with opposite order via S_OUT_RTZ.
- Bit 3 with dt=df=1 for one cycle → err=1 persists. A later all_valid word is not captured. Reset → err=0 and capture resumes.
- TIMEOUT=15: capture, never assert ack_nxt → timeout=1 on the 15th cycle in S_HOLD. Assert reset mid-HOLD → all outputs return to reset values next edge.
